// File: rtl/truth_table_eval.sv
// Programmable N-input Boolean function held as a serially loadable truth table,
// with registered single-vector evaluation and an on-chip sweep over all minterms.
module truth_table_eval #(
    parameter int unsigned              N_IN    = 4,
    parameter logic [(1 << N_IN) - 1:0] TT_INIT = 16'hAAEA
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_en,
    input  logic            cfg_bit,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_valid,
    output logic            f_out,
    output logic            f_valid,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_count,
    output logic [N_IN-1:0] first_zero_idx,
    output logic            zero_found
);

    localparam int unsigned     TtW     = 1 << N_IN;
    localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e            state_q, state_d;
    logic [TtW-1:0]    tt_q, tt_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN:0]     acc_q, acc_d;
    logic              zf_q, zf_d;
    logic [N_IN-1:0]   fz_q, fz_d;
    logic              f_out_q, f_out_d;
    logic              f_valid_q, f_valid_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic [N_IN-1:0]   fzi_q, fzi_d;
    logic              zfo_q, zfo_d;
    logic              cur_bit;

    assign cur_bit = tt_q[idx_q];

    always_comb begin
        state_d   = state_q;
        tt_d      = tt_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        zf_d      = zf_q;
        fz_d      = fz_q;
        f_out_d   = f_out_q;
        f_valid_d = 1'b0;
        ones_d    = ones_q;
        fzi_d     = fzi_q;
        zfo_d     = zfo_q;

        unique case (state_q)
            StIdle: begin
                // Evaluation reads the table before any same-cycle shift.
                if (in_valid) begin
                    f_out_d   = tt_q[in_vec];
                    f_valid_d = 1'b1;
                end
                if (start) begin
                    state_d = StSweep;
                    idx_d   = '0;
                    acc_d   = '0;
                    zf_d    = 1'b0;
                    fz_d    = '0;
                end else if (cfg_en) begin
                    tt_d = {cfg_bit, tt_q[TtW-1:1]};
                end
            end
            StSweep: begin
                acc_d = acc_q + (N_IN + 1)'(cur_bit);
                if (!cur_bit && !zf_q) begin
                    fz_d = idx_q;
                    zf_d = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    // Results load on the final edge so they are visible with done.
                    state_d = StDone;
                    ones_d  = acc_d;
                    fzi_d   = fz_d;
                    zfo_d   = zf_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tt_q      <= TT_INIT;
            idx_q     <= '0;
            acc_q     <= '0;
            zf_q      <= 1'b0;
            fz_q      <= '0;
            f_out_q   <= 1'b0;
            f_valid_q <= 1'b0;
            ones_q    <= '0;
            fzi_q     <= '0;
            zfo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tt_q      <= tt_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            zf_q      <= zf_d;
            fz_q      <= fz_d;
            f_out_q   <= f_out_d;
            f_valid_q <= f_valid_d;
            ones_q    <= ones_d;
            fzi_q     <= fzi_d;
            zfo_q     <= zfo_d;
        end
    end

    assign f_out          = f_out_q;
    assign f_valid        = f_valid_q;
    assign busy           = (state_q == StSweep);
    assign done           = (state_q == StDone);
    assign ones_count     = ones_q;
    assign first_zero_idx = fzi_q;
    assign zero_found     = zfo_q;

endmodule

// File: tb/tb_truth_table_eval.sv
// Randomised and directed bench for truth_table_eval against a table-level reference model.
module tb_truth_table_eval;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 1 << N;
    localparam logic [W-1:0] INIT = 16'hAAEA;

    logic         clk = 1'b0;
    logic         rst_n, cfg_en, cfg_bit, in_valid, start;
    logic [N-1:0] in_vec;
    logic         f_out, f_valid, busy, done, zero_found;
    logic [N:0]   ones_count;
    logic [N-1:0] first_zero_idx;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] tt_m;
    logic         f_out_m;

    truth_table_eval #(.N_IN(N), .TT_INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
        .in_vec(in_vec), .in_valid(in_valid), .f_out(f_out), .f_valid(f_valid),
        .start(start), .busy(busy), .done(done), .ones_count(ones_count),
        .first_zero_idx(first_zero_idx), .zero_found(zero_found)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_en = 0; cfg_bit = 0; in_valid = 0; in_vec = '0; start = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
        tt_m = INIT;
        f_out_m = 0;
    endtask

    // One idle-state cycle: optional evaluation and config shift, then check.
    task automatic step(input logic ce, input logic cb, input logic iv, input logic [N-1:0] v);
        cfg_en = ce; cfg_bit = cb; in_valid = iv; in_vec = v; start = 0;
        if (iv) f_out_m = tt_m[v];
        if (ce) tt_m = {cb, tt_m[W-1:1]};
        tick();
        check_eq("f_valid", {31'b0, f_valid}, {31'b0, iv});
        check_eq("f_out", {31'b0, f_out}, {31'b0, f_out_m});
        idle_inputs();
    endtask

    // Full sweep; disturb drives eval/start/cfg (cfg_bit=0) during busy, which must be ignored.
    task automatic run_sweep(input bit disturb, input logic iv, input logic [N-1:0] v);
        int n;
        int exp_ones;
        int exp_fz;
        bit exp_zf;
        exp_ones = $countones(tt_m);
        exp_zf = 0;
        exp_fz = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (!tt_m[i] && !exp_zf) begin
                exp_zf = 1;
                exp_fz = i;
            end
        end
        start = 1; in_valid = iv; in_vec = v; cfg_en = 1; cfg_bit = ~tt_m[W-1];
        if (iv) f_out_m = tt_m[v];
        tick();
        check_eq("start_eval_valid", {31'b0, f_valid}, {31'b0, iv});
        check_eq("start_eval_out", {31'b0, f_out}, {31'b0, f_out_m});
        idle_inputs();
        n = 0;
        while (busy && n < 40) begin
            check_eq("done_while_busy", {31'b0, done}, 0);
            if (n > 0) check_eq("no_eval_busy", {31'b0, f_valid}, 0);
            if (disturb) begin
                in_valid = 1; in_vec = N'($urandom); start = 1; cfg_en = 1; cfg_bit = 0;
            end
            n++;
            tick();
        end
        idle_inputs();
        check_eq("busy_cycles", n, W);
        check_eq("done_pulse", {31'b0, done}, 1);
        check_eq("f_valid_done", {31'b0, f_valid}, 0);
        check_eq("ones_count", {27'b0, ones_count}, exp_ones);
        check_eq("first_zero_idx", {28'b0, first_zero_idx}, exp_fz);
        check_eq("zero_found", {31'b0, zero_found}, {31'b0, exp_zf});
        tick();
        check_eq("done_one_cycle", {31'b0, done}, 0);
        check_eq("busy_after", {31'b0, busy}, 0);
    endtask

    initial begin
        do_reset();
        check_eq("rst_f_out", {31'b0, f_out}, 0);
        check_eq("rst_f_valid", {31'b0, f_valid}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_ones", {27'b0, ones_count}, 0);
        check_eq("rst_fz", {28'b0, first_zero_idx}, 0);
        check_eq("rst_zf", {31'b0, zero_found}, 0);

        // Back-to-back evaluation of every index from the reset table
        for (int v = 0; v < int'(W); v++) step(0, 0, 1, N'(v));
        tick();
        check_eq("f_valid_drop", {31'b0, f_valid}, 0);
        check_eq("f_out_hold", {31'b0, f_out}, {31'b0, f_out_m});

        // Reset-table sweep: 9 ones, first zero at 0
        run_sweep(0, 0, '0);
        check_eq("init_ones_const", {27'b0, ones_count}, 9);

        // All-ones table, then a single zero at bit 0
        for (int i = 0; i < int'(W); i++) step(1, 1, 0, '0);
        run_sweep(0, 0, '0);
        step(1, 0, 0, '0);
        for (int i = 1; i < int'(W); i++) step(1, 1, 0, '0);
        run_sweep(0, 1, N'(5));
        check_eq("one_zero_ones_const", {27'b0, ones_count}, 15);

        // Disturbance during sweep must not change the table
        do_reset();
        run_sweep(1, 0, '0);
        run_sweep(0, 0, '0);
        check_eq("resweep_ones_const", {27'b0, ones_count}, 9);

        // Reset on the 8th busy cycle aborts the sweep
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("busy_8th", {31'b0, busy}, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        tt_m = INIT;
        f_out_m = 0;
        check_eq("abort_busy", {31'b0, busy}, 0);
        check_eq("abort_ones", {27'b0, ones_count}, 0);
        check_eq("abort_zf", {31'b0, zero_found}, 0);
        for (int i = 0; i < 20; i++) begin
            check_eq("abort_no_done", {31'b0, done}, 0);
            tick();
        end
        run_sweep(0, 0, '0);

        // Same-cycle shift and evaluate uses the old table
        step(1, 1, 1, '0);
        check_eq("old_tt0", {31'b0, f_out}, 0);
        step(0, 0, 1, '0);
        check_eq("shifted_tt0", {31'b0, f_out}, 1);

        // Randomised mix of config, evaluation and sweeps
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 24) == 0)
                run_sweep(1'($urandom), 1'($urandom), N'($urandom));
            else
                step(1'($urandom), 1'($urandom), 1'($urandom), N'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_eval.md
Name: truth_table_eval

Overview:
- Parametrised, programmable N-input Boolean function unit.
- Holds the function as a loadable truth table instead of fixed gates.
- Evaluates input vectors with a 1-cycle registered latency.
- Runs a sweep over all 2^N_IN input combinations. The sweep reports the minterm (ones) count and the lowest maxterm (zero) index, so a function can be characterised on-chip.

Parameters:
- N_IN, 4, number of function inputs (legal 2..8). Index bit N_IN-1 is the first/most-significant variable.
- TT_INIT, 16'hAAEA (width 2^N_IN), truth table loaded at reset. Bit k is F for input index k.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cfg_en  input  1  shift one truth-table bit this cycle
- cfg_bit  input  1  serial truth-table data
- in_vec  input  N_IN  input combination to evaluate
- in_valid  input  1  evaluate in_vec this cycle
- f_out  output  1  registered function value
- f_valid  output  1  one-cycle pulse qualifying f_out
- start  input  1  request a full sweep
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse, sweep results updated
- ones_count  output  N_IN+1  number of true minterms from the last sweep
- first_zero_idx  output  N_IN  lowest index with F=0 from the last sweep; 0 if none
- zero_found  output  1  last sweep found at least one F=0

Behaviour:
- Reset (rst_n=0 at a clk edge; one clock, one domain)
  - TT <= TT_INIT; FSM <= IDLE.
  - f_out=0, f_valid=0, busy=0, done=0, ones_count=0, first_zero_idx=0, zero_found=0.
  - Internal index and accumulator cleared.
  - Reset mid-sweep aborts the sweep: no done pulse, results stay 0.
- Storage
  - TT is a 2^N_IN-bit register.
  - Config shift: when cfg_en=1 and FSM=IDLE and start=0, TT <= {cfg_bit, TT[2^N_IN-1:1]}.
  - After 2^N_IN shifts, the first bit shifted in lands in bit 0.
  - cfg_en is ignored while busy, in DONE, or when start=1 in the same cycle.
- Evaluate
  - When in_valid=1 and FSM=IDLE: next cycle f_out=TT[in_vec], f_valid=1.
  - When in_valid=0: f_valid=0 and f_out holds its last value.
  - in_valid while not IDLE is dropped (f_valid stays 0).
  - When in_valid and cfg_en occur in the same cycle, the evaluation uses TT before the shift.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on start=1; idx<=0, acc<=0, zf<=0, fz<=0.
  - SWEEP, each cycle:
    - acc += TT[idx].
    - If TT[idx]=0 and zf=0: fz<=idx, zf<=1.
    - If idx = 2^N_IN-1, go to DONE; else idx++.
    - Use the updated acc/fz/zf, including the last index, when the results are loaded.
  - SWEEP -> DONE after the last index.
  - DONE, one cycle: load ones_count, first_zero_idx, zero_found; done=1; then -> IDLE.
  - start in SWEEP or DONE is ignored. start in IDLE is accepted even if in_valid is also high; that evaluation is performed.
- Timing
  - Start sampled at edge t: busy=1 for cycles t+1 .. t+2^N_IN, exactly 2^N_IN cycles.
  - done=1 and new results visible in cycle t+2^N_IN+1; busy=0 in that cycle.
  - Results hold until the next done or reset.
- Widths
  - acc is N_IN+1 bits, enough for an all-ones table of 2^N_IN.
  - idx is N_IN bits; it never wraps because the terminal compare ends the sweep.

Test Plan:
1. After reset, apply in_vec 0..15 with in_valid=1 back-to-back -> f_valid each following cycle. f_out=1 for 1,3,5,6,7,9,11,13,15 and 0 for 0,2,4,8,10,12,14.
2. Pulse start after reset -> busy high exactly 16 cycles. done pulses the next cycle with ones_count=9, first_zero_idx=0, zero_found=1.
3. Shift 16 cfg bits of 1 -> sweep gives ones_count=16, zero_found=0, first_zero_idx=0. Then shift 0,then 15 ones (cfg_bit 0 first) -> after 16 more shifts, sweep gives ones_count=15, first_zero_idx=0, zero_found=1.
4. During a sweep, drive in_valid, start and cfg_en (cfg_bit=0) -> no f_valid, no restart, TT unchanged. A re-sweep gives ones_count=9.
5. Assert rst_n=0 for one cycle on the 8th busy cycle -> next cycle busy=0, ones_count=0, no done pulse. A new sweep returns 9.
6. In the same cycle, cfg_en=1 with cfg_bit=1 and in_valid=1 with in_vec=0 -> f_out=0 (old table). After the shift, a second evaluation of in_vec=0 gives f_out=TT[1] of the old table, i.e. 1.
